// File: rtl/cic_comb_chain.sv
// ----------------------------------------------------------------------------
// cic_comb_chain
//
// Comb section of a CIC decimator. It runs at the decimated rate and is
// qualified by in_valid. NSTG cascaded combs each compute
// y[n] = x[n] - x[n-DM] modulo 2^IDW. The final comb result is arithmetically
// shifted right by os_sel (floor), then saturated to ODW bits.
//
// A small IDLE/FILL/RUN controller suppresses the first NSTG*DM results after
// the chain is armed or re-armed. Those results still depend on the zeroed
// delay-line history, so they are not meaningful output samples.
//
// Ports
//   clk         single clock, rising edge
//   reset_n     asynchronous active-low reset
//   os_sel      0/7 = disabled (IDLE), 1..6 = output right-shift amount
//   in_valid    data_in qualifier (decimated-rate strobe)
//   data_in     signed IDW-bit integrator-section sample
//   clr_ovf     synchronous clear of ovf_sticky (a set in the same cycle wins)
//   out_valid   one-cycle pulse per produced result
//   data_out    signed ODW-bit scaled, saturated result; holds between pulses
//   ovf_sticky  set when any emitted result saturates
//   busy        high while the chain is warming up (FILL)
// ----------------------------------------------------------------------------
module cic_comb_chain #(
    parameter int IDW  = 23,
    parameter int ODW  = 16,
    parameter int NSTG = 4,
    parameter int DM   = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [2:0]     os_sel,
    input  logic           in_valid,
    input  logic [IDW-1:0] data_in,
    input  logic           clr_ovf,
    output logic           out_valid,
    output logic [ODW-1:0] data_out,
    output logic           ovf_sticky,
    output logic           busy
);

    localparam int FILL_N = NSTG * DM;
    localparam int CW     = $clog2(FILL_N + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     sel_q, sel_d;

    logic [2:0]     sel_eff;
    logic           flush;
    logic           accept;
    logic           acc_sup;

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    // sel_q holds the shift that armed the chain. Any departure from it, either
    // to disabled or to another shift, flushes everything in flight. The sample
    // presented in a flush cycle is discarded.
    always_comb begin
        sel_eff = (os_sel == 3'd7) ? 3'd0 : os_sel;
        flush   = (sel_eff == 3'd0) || ((state_q != ST_IDLE) && (sel_eff != sel_q));
        accept  = in_valid && (state_q != ST_IDLE) && !flush;
        acc_sup = (state_q == ST_FILL);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_eff != 3'd0) begin
                    state_d = ST_FILL;
                    cnt_d   = CW'(FILL_N);
                    sel_d   = sel_eff;
                end
            end
            default: begin
                if (sel_eff == 3'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sel_eff != sel_q) begin
                    state_d = ST_FILL;
                    cnt_d   = CW'(FILL_N);
                    sel_d   = sel_eff;
                end else if ((state_q == ST_FILL) && accept) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    assign busy = (state_q == ST_FILL);

    // ------------------------------------------------------------------------
    // Comb stages
    // ------------------------------------------------------------------------
    // Each stage carries a valid bit and a suppress tag. The tag marks samples
    // accepted during FILL, so their results pass through the chain but never
    // reach out_valid.
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
        logic           vin;
        logic           sin;
        logic [IDW-1:0] xin;
        logic           v_q;
        logic           s_q;
        logic [IDW-1:0] y_q;
        logic [IDW-1:0] dly_q [DM];

        if (gi == 0) begin : g_head
            assign vin = accept;
            assign sin = acc_sup;
            assign xin = data_in;
        end else begin : g_tail
            assign vin = g_stage[gi-1].v_q;
            assign sin = g_stage[gi-1].s_q;
            assign xin = g_stage[gi-1].y_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q <= 1'b0;
                s_q <= 1'b0;
                y_q <= '0;
                for (int j = 0; j < DM; j++) begin
                    dly_q[j] <= '0;
                end
            end else if (flush) begin
                v_q <= 1'b0;
                s_q <= 1'b0;
                y_q <= '0;
                for (int j = 0; j < DM; j++) begin
                    dly_q[j] <= '0;
                end
            end else begin
                v_q <= vin;
                s_q <= vin & sin;
                if (vin) begin
                    // Plain IDW-bit subtraction wraps modulo 2^IDW, which CIC needs.
                    y_q      <= xin - dly_q[DM-1];
                    dly_q[0] <= xin;
                    for (int j = 1; j < DM; j++) begin
                        dly_q[j] <= dly_q[j-1];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output scaling / saturation
    // ------------------------------------------------------------------------
    logic                  last_v;
    logic                  last_s;
    logic [IDW-1:0]        last_y;
    logic signed [IDW-1:0] shifted;
    logic [IDW-ODW:0]      hi_bits;
    logic                  in_range;
    logic [ODW-1:0]        sat_val;
    logic                  fire;

    assign last_v = g_stage[NSTG-1].v_q;
    assign last_s = g_stage[NSTG-1].s_q;
    assign last_y = g_stage[NSTG-1].y_q;

    always_comb begin
        shifted  = $signed(last_y) >>> sel_q;
        // The value fits in ODW bits exactly when every bit from the ODW-1
        // sign position upward is a copy of the sign.
        hi_bits  = shifted[IDW-1:ODW-1];
        in_range = (&hi_bits) || !(|hi_bits);
        if (in_range) begin
            sat_val = shifted[ODW-1:0];
        end else if (shifted[IDW-1]) begin
            sat_val = {1'b1, {(ODW-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(ODW-1){1'b1}}};
        end
        fire = last_v && !last_s && !flush;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            out_valid  <= fire;
            if (fire) begin
                data_out <= sat_val;
            end
            ovf_sticky <= (fire && !in_range) || (ovf_sticky && !clr_ovf);
        end
    end

endmodule

// File: tb/tb_cic_comb_chain.sv
// ----------------------------------------------------------------------------
// tb_cic_comb_chain
//
// Three chains (N=1/DM=1, N=4/DM=1, N=3/DM=2) share one stimulus stream. Each
// chain has a reference model that computes the cascaded comb result directly
// as the binomial expansion of (1 - z^-DM)^N over the accepted-sample history.
// The models schedule each expected result N+1 cycles after its input and
// compare every DUT output on every cycle.
// ----------------------------------------------------------------------------
module tb_cic_comb_chain;

    localparam int IDW = 23;
    localparam int ODW = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  os_sel;
    logic        in_valid;
    logic [IDW-1:0] data_in;
    logic        clr_ovf;

    logic              ov_w   [3];
    logic signed [ODW-1:0] dout_w [3];
    logic              ovf_w  [3];
    logic              busy_w [3];

    always #5 clk = ~clk;

    cic_comb_chain #(.IDW(IDW), .ODW(ODW), .NSTG(1), .DM(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .os_sel(os_sel), .in_valid(in_valid),
        .data_in(data_in), .clr_ovf(clr_ovf), .out_valid(ov_w[0]),
        .data_out(dout_w[0]), .ovf_sticky(ovf_w[0]), .busy(busy_w[0]));

    cic_comb_chain #(.IDW(IDW), .ODW(ODW), .NSTG(4), .DM(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .os_sel(os_sel), .in_valid(in_valid),
        .data_in(data_in), .clr_ovf(clr_ovf), .out_valid(ov_w[1]),
        .data_out(dout_w[1]), .ovf_sticky(ovf_w[1]), .busy(busy_w[1]));

    cic_comb_chain #(.IDW(IDW), .ODW(ODW), .NSTG(3), .DM(2)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .os_sel(os_sel), .in_valid(in_valid),
        .data_in(data_in), .clr_ovf(clr_ovf), .out_valid(ov_w[2]),
        .data_out(dout_w[2]), .ovf_sticky(ovf_w[2]), .busy(busy_w[2]));

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    bit     armed  [3];
    int     cur    [3];
    int     hcnt   [3];
    longint hist   [3][64];
    bit     ev_v   [3][16];
    longint ev_d   [3][16];
    bit     ev_s   [3][16];
    longint m_last [3];
    bit     m_ovf  [3];
    bit     m_ov   [3];
    bit     m_busy [3];
    int     pulses [3];
    int     ecnt = 0;

    function automatic int nst(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int dmv(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int t = 1; t <= k; t++) r = r * (n - k + t) / t;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            armed[i] = 0; cur[i] = 0; hcnt[i] = 0;
            m_last[i] = 0; m_ovf[i] = 0; m_ov[i] = 0; m_busy[i] = 0;
            for (int s = 0; s < 16; s++) ev_v[i][s] = 0;
        end
    endtask

    task automatic model_edge();
        int     eff;
        int     slot;
        bit     do_flush;
        bit     acc;
        bit     new_ovf;
        longint acc_sum;
        longint w;
        longint sh;
        logic [IDW-1:0] lo;
        eff  = (os_sel == 3'd7) ? 0 : int'(os_sel);
        slot = ecnt % 16;
        for (int i = 0; i < 3; i++) begin
            do_flush = 0;
            acc      = 0;
            if (eff == 0) begin
                do_flush = armed[i];
                armed[i] = 0;
            end else if (!armed[i]) begin
                armed[i] = 1; cur[i] = eff; hcnt[i] = 0;
            end else if (eff != cur[i]) begin
                do_flush = 1; cur[i] = eff;
            end else if (in_valid) begin
                acc = 1;
            end
            if (do_flush) begin
                hcnt[i] = 0;
                for (int s = 0; s < 16; s++) ev_v[i][s] = 0;
            end
            m_ov[i] = ev_v[i][slot];
            new_ovf = clr_ovf ? 1'b0 : m_ovf[i];
            if (m_ov[i]) begin
                m_last[i] = ev_d[i][slot];
                if (ev_s[i][slot]) new_ovf = 1'b1;
            end
            m_ovf[i] = new_ovf;
            ev_v[i][slot] = 0;
            if (acc) begin
                hist[i][hcnt[i] % 64] = longint'($signed(data_in));
                acc_sum = 0;
                for (int k = 0; k <= nst(i); k++) begin
                    int idx;
                    idx = hcnt[i] - k * dmv(i);
                    if (idx >= 0)
                        acc_sum += ((k % 2) ? -1 : 1) * binom(nst(i), k) * hist[i][idx % 64];
                end
                lo = acc_sum[IDW-1:0];
                w  = longint'($signed(lo));
                sh = w >>> cur[i];
                if (hcnt[i] >= nst(i) * dmv(i)) begin
                    int ts;
                    ts = (ecnt + nst(i)) % 16;
                    ev_v[i][ts] = 1;
                    ev_s[i][ts] = (sh > 32767) || (sh < -32768);
                    ev_d[i][ts] = (sh > 32767) ? 32767 : ((sh < -32768) ? -32768 : sh);
                end
                hcnt[i]++;
            end
            m_busy[i] = armed[i] && (hcnt[i] < nst(i) * dmv(i));
        end
        ecnt++;
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("ov%0d_c%0d", i, ecnt), ov_w[i], m_ov[i]);
            check_eq($sformatf("dout%0d_c%0d", i, ecnt), dout_w[i], m_last[i]);
            check_eq($sformatf("ovf%0d_c%0d", i, ecnt), ovf_w[i], m_ovf[i]);
            check_eq($sformatf("busy%0d_c%0d", i, ecnt), busy_w[i], m_busy[i]);
            if (ov_w[i]) pulses[i]++;
        end
    endtask

    task automatic step(input logic [2:0] os, input bit v, input longint d, input bit clr);
        os_sel   = os;
        in_valid = v;
        data_in  = d[IDW-1:0];
        clr_ovf  = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic mid_reset(input string tag);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("%s_ov%0d", tag, i), ov_w[i], 0);
            check_eq($sformatf("%s_dout%0d", tag, i), dout_w[i], 0);
            check_eq($sformatf("%s_ovf%0d", tag, i), ovf_w[i], 0);
            check_eq($sformatf("%s_busy%0d", tag, i), busy_w[i], 0);
        end
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        os_sel   = 3'd0;
        in_valid = 1'b0;
        data_in  = '0;
        clr_ovf  = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) pulses[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        mid_reset("reset");
        $display("TXN reset checked");

        // Short N=1 sequence: the first result is suppressed, then 50 and 100 follow.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 100, 0);
        check_eq("r031_sup", ov_w[0], 0);
        step(1, 1, 300, 0);
        check_eq("r031_v1", ov_w[0], 1);
        check_eq("r031_d1", dout_w[0], 50);
        step(1, 0, 0, 0);
        check_eq("r031_v2", ov_w[0], 1);
        check_eq("r031_d2", dout_w[0], 100);
        $display("TXN seq 0,100,300 -> %0d", dout_w[0]);

        // Saturation in both directions, then clear of the sticky flag.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 100000, 0);
        step(1, 1, 0, 0);
        check_eq("r032_pos", dout_w[0], 32767);
        check_eq("r032_ovf", ovf_w[0], 1);
        step(1, 0, 0, 0);
        check_eq("r032_neg", dout_w[0], -32768);
        step(1, 0, 0, 1);
        check_eq("r032_clr", ovf_w[0], 0);
        $display("TXN saturation ovf_sticky=%0d", ovf_w[0]);

        // Modular wrap of the difference, with no overflow reported.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 4194300, 0);
        step(1, 1, -4194300, 0);
        step(1, 0, 0, 0);
        check_eq("r033_d", dout_w[0], 4);
        check_eq("r033_ovf", ovf_w[0], 0);
        $display("TXN wrap -> %0d", dout_w[0]);

        // N=4 constant input: exactly four suppressed results, then zeros.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("r034_busy0", busy_w[1], 1);
        pulses[1] = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 1000, 0);
            check_eq($sformatf("r034_busy%0d", k + 1), busy_w[1], (k < 3) ? 1 : 0);
        end
        for (int k = 0; k < 6; k++) step(1, 1, 1000, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
        check_eq("r034_pulses", pulses[1], 6);
        check_eq("r034_d", dout_w[1], 0);
        $display("TXN constant 1000 pulses=%0d", pulses[1]);

        // Shift change 2->3 while in RUN re-enters FILL.
        step(2, 0, 0, 0);
        for (int k = 0; k < 10; k++) step(2, 1, longint'($urandom_range(0, 4000)) - 2000, 0);
        step(3, 1, 777, 0);
        check_eq("r035_busy", busy_w[1], 1);
        pulses[1] = 0;
        for (int k = 0; k < 4; k++) begin
            step(3, 1, longint'($urandom_range(0, 4000)) - 2000, 0);
            check_eq($sformatf("r035_quiet%0d", k), ov_w[1], 0);
        end
        for (int k = 0; k < 4; k++) step(3, 1, longint'($urandom_range(0, 4000)) - 2000, 0);
        for (int k = 0; k < 4; k++) step(3, 0, 0, 0);
        check_eq("r035_pulses", pulses[1], 4);
        $display("TXN shift change pulses=%0d", pulses[1]);

        // Reset asserted while results are still in flight.
        for (int k = 0; k < 3; k++) step(3, 1, longint'($urandom_range(0, 4000)) - 2000, 0);
        mid_reset("r036");
        pulses[1] = 0;
        for (int k = 0; k < 5; k++) step(3, 1, longint'($urandom_range(0, 4000)) - 2000, 0);
        check_eq("r036_nopulse", pulses[1], 0);
        $display("TXN mid-stream reset");

        // Randomized traffic.
        begin
            logic [2:0] os_r;
            os_r = 3'd2;
            for (int c = 0; c < 900; c++) begin
                int unsigned r;
                longint d;
                logic [IDW-1:0] raw;
                r = $urandom;
                if ($urandom_range(0, 59) == 0) os_r = 3'($urandom_range(0, 7));
                else if (os_r == 3'd0 && $urandom_range(0, 4) == 0) os_r = 3'($urandom_range(1, 6));
                raw = r[IDW-1:0];
                d = ($urandom_range(0, 1) == 0) ? longint'($urandom_range(0, 6000)) - 3000
                                                : longint'($signed(raw));
                step(os_r, ($urandom_range(0, 3) != 0), d, ($urandom_range(0, 19) == 0));
                if (c % 100 == 99) $display("TXN random block %0d checks=%0d", c / 100, checks);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
